// File: rtl/demux_pkg.sv
//------------------------------------------------------------------------------
// Module   : demux_pkg
// Purpose  : Shared widths, sel encodings and slot state type for demux32_3_reg.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package demux_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    localparam logic [1:0] SEL_A   = 2'b00;
    localparam logic [1:0] SEL_B   = 2'b01;
    localparam logic [1:0] SEL_C   = 2'b10;
    localparam logic [1:0] SEL_BAD = 2'b11;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

`default_nettype wire

// File: rtl/demux_slot.sv
//------------------------------------------------------------------------------
// Module   : demux_slot
// Purpose  : One-entry holding register with load/deliver handshake; optional
//            delivered-word counter under DEMUX32_3_COUNT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module demux_slot
    import demux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
`ifdef DEMUX32_3_COUNT_EN
    output logic [CNT_W-1:0]  o_cnt,
`endif
    output logic              o_room
);

    slot_state_t       r_state;
    slot_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_data;
    logic              w_deliver;

    assign w_deliver = (r_state == SLOT_FULL) && i_out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A load wins over delivery so a same-cycle deliver+load stays FULL.
    always_comb begin
        w_state_nxt = r_state;
        if (i_load) begin
            w_state_nxt = SLOT_FULL;
        end else if (w_deliver) begin
            w_state_nxt = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

`ifdef DEMUX32_3_COUNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_deliver) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
`endif

    assign o_data  = r_data;
    assign o_valid = (r_state == SLOT_FULL);
    assign o_room  = (r_state == SLOT_EMPTY) || i_out_ready;

endmodule

`default_nettype wire

// File: rtl/demux32_3_reg.sv
//------------------------------------------------------------------------------
// Module   : demux32_3_reg
// Purpose  : Routes a 32-bit word to one of three one-entry output slots.
//            Optional counters enabled by macro DEMUX32_3_COUNT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module demux32_3_reg
    import demux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        sel,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_c,
    output logic              out_a_valid,
    output logic              out_b_valid,
    output logic              out_c_valid,
    input  logic              out_a_ready,
    input  logic              out_b_ready,
    input  logic              out_c_ready,
`ifdef DEMUX32_3_COUNT_EN
    output logic [CNT_W-1:0]  cnt_a,
    output logic [CNT_W-1:0]  cnt_b,
    output logic [CNT_W-1:0]  cnt_c,
`endif
    output logic              sel_err
);

    logic [2:0]        w_load;
    logic [2:0]        w_room;
    logic [2:0]        w_valid;
    logic [2:0]        w_out_ready;
    logic [DATA_W-1:0] w_data [3];
    logic              w_in_ready;
    logic              w_accept;
    logic              r_sel_err;
`ifdef DEMUX32_3_COUNT_EN
    logic [CNT_W-1:0]  w_cnt [3];
`endif

    assign w_out_ready = {out_c_ready, out_b_ready, out_a_ready};

    // A bad sel is always accepted so the producer never stalls on it.
    always_comb begin
        w_in_ready = 1'b0;
        if (!rst) begin
            case (sel)
                SEL_A:   w_in_ready = w_room[0];
                SEL_B:   w_in_ready = w_room[1];
                SEL_C:   w_in_ready = w_room[2];
                default: w_in_ready = 1'b1;
            endcase
        end
    end

    assign in_ready = w_in_ready;
    assign w_accept = in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= w_accept && (sel == SEL_BAD);
        end
    end

    assign sel_err = r_sel_err;

    for (genvar gi = 0; gi < 3; gi++) begin : g_slot
        assign w_load[gi] = w_accept && (sel == 2'(gi));

        demux_slot u_slot (
            .clk         (clk),
            .rst         (rst),
            .i_load      (w_load[gi]),
            .i_data      (in_data),
            .i_out_ready (w_out_ready[gi]),
            .o_data      (w_data[gi]),
            .o_valid     (w_valid[gi]),
`ifdef DEMUX32_3_COUNT_EN
            .o_cnt       (w_cnt[gi]),
`endif
            .o_room      (w_room[gi])
        );
    end

    assign out_a       = w_data[0];
    assign out_b       = w_data[1];
    assign out_c       = w_data[2];
    assign out_a_valid = w_valid[0];
    assign out_b_valid = w_valid[1];
    assign out_c_valid = w_valid[2];

`ifdef DEMUX32_3_COUNT_EN
    assign cnt_a = w_cnt[0];
    assign cnt_b = w_cnt[1];
    assign cnt_c = w_cnt[2];
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux32_3_reg.sv
//------------------------------------------------------------------------------
// Module   : tb_demux32_3_reg
// Purpose  : Self-checking bench for demux32_3_reg (covers DEMUX32_3_COUNT_EN).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_demux32_3_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = 32'h5;
    logic        in_valid = 1'b1;
    logic        in_ready;
    logic [1:0]  sel = 2'b00;
    logic [31:0] out_a, out_b, out_c;
    logic        out_a_valid, out_b_valid, out_c_valid;
    logic        out_a_ready = 1'b1;
    logic        out_b_ready = 1'b1;
    logic        out_c_ready = 1'b1;
    logic        sel_err;
`ifdef DEMUX32_3_COUNT_EN
    logic [15:0] cnt_a, cnt_b, cnt_c;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux32_3_reg dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sel         (sel),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_c       (out_c),
        .out_a_valid (out_a_valid),
        .out_b_valid (out_b_valid),
        .out_c_valid (out_c_valid),
        .out_a_ready (out_a_ready),
        .out_b_ready (out_b_ready),
        .out_c_ready (out_c_ready),
`ifdef DEMUX32_3_COUNT_EN
        .cnt_a       (cnt_a),
        .cnt_b       (cnt_b),
        .cnt_c       (cnt_c),
`endif
        .sel_err     (sel_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: state after each edge, computed from inputs seen at the
    // preceding negedge; delivered words are checked against a per-slot queue.
    logic [2:0]  m_full = 3'b000;
    logic        m_err  = 1'b0;
    logic [31:0] m_last [3] = '{32'h0, 32'h0, 32'h0};
    logic [15:0] m_cnt  [3] = '{16'h0, 16'h0, 16'h0};
    logic [31:0] sb     [3][$];

    always @(negedge clk) begin
        logic        exp_ready;
        logic        ld;
        logic [2:0]  rdy;
        logic [2:0]  vld;
        logic [31:0] od [3];
        logic [31:0] e;
        int          s;
        rdy   = {out_c_ready, out_b_ready, out_a_ready};
        vld   = {out_c_valid, out_b_valid, out_a_valid};
        od[0] = out_a;
        od[1] = out_b;
        od[2] = out_c;
        s     = int'(sel);
        if (sel == 2'b11) exp_ready = !rst;
        else              exp_ready = !rst && (!m_full[s] || rdy[s]);

        chk("mon_in_ready", {31'h0, in_ready}, {31'h0, exp_ready});
        chk("mon_sel_err", {31'h0, sel_err}, {31'h0, m_err});
        for (int x = 0; x < 3; x++) begin
            chk($sformatf("mon_valid_%0d", x), {31'h0, vld[x]}, {31'h0, m_full[x]});
            chk($sformatf("mon_data_%0d", x), od[x], m_last[x]);
        end

        if (rst) begin
            m_full = 3'b000;
            m_err  = 1'b0;
            for (int x = 0; x < 3; x++) begin
                m_last[x] = 32'h0;
                m_cnt[x]  = 16'h0;
                sb[x].delete();
            end
        end else begin
            m_err = in_valid && exp_ready && (sel == 2'b11);
            for (int x = 0; x < 3; x++) begin
                if (m_full[x] && rdy[x] && sb[x].size() > 0) begin
                    e = sb[x].pop_front();
                    chk($sformatf("deliver_%0d", x), od[x], e);
                    m_cnt[x] = m_cnt[x] + 16'h1;
                end
                ld = in_valid && exp_ready && (s == x);
                if (ld) begin
                    sb[x].push_back(in_data);
                    m_last[x] = in_data;
                end
                m_full[x] = ld | (m_full[x] & ~rdy[x]);
            end
        end
    end

    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d,
                         input logic ra, input logic rb, input logic rc);
        @(posedge clk);
        #1;
        in_valid    = v;
        sel         = s;
        in_data     = d;
        out_a_ready = ra;
        out_b_ready = rb;
        out_c_ready = rc;
    endtask

    initial begin
        // Reset held two cycles with a valid word pending.
        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
            chk("rst_valids", {29'h0, out_c_valid, out_b_valid, out_a_valid}, 32'h0);
            chk("rst_out_a", out_a, 32'h0);
            chk("rst_sel_err", {31'h0, sel_err}, 32'h0);
        end
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;

        // Routing to B.
        drive(1'b1, 2'b01, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("route_b_valid", {31'h0, out_b_valid}, 32'h1);
        chk("route_b_data", out_b, 32'hDEADBEEF);
        chk("route_ac_valid", {30'h0, out_c_valid, out_a_valid}, 32'h0);

        // Backpressure on A.
        drive(1'b1, 2'b00, 32'h1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("bp_ready_first", {31'h0, in_ready}, 32'h1);
        drive(1'b1, 2'b00, 32'h2, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("bp_ready_drop", {31'h0, in_ready}, 32'h0);
        chk("bp_hold_1", out_a, 32'h1);
        drive(1'b1, 2'b00, 32'h2, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("bp_ready_still", {31'h0, in_ready}, 32'h0);
        chk("bp_hold_2", out_a, 32'h1);
        drive(1'b1, 2'b00, 32'h2, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("bp_ready_rise", {31'h0, in_ready}, 32'h1);
        drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("bp_no_bubble_valid", {31'h0, out_a_valid}, 32'h1);
        chk("bp_no_bubble_data", out_a, 32'h2);
        drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("bp_drained", {31'h0, out_a_valid}, 32'h0);
        chk("bp_retain", out_a, 32'h2);

        // Back-to-back stream into C.
        drive(1'b1, 2'b10, 32'h10, 1'b1, 1'b1, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            if (i < 3) drive(1'b1, 2'b10, 32'h10 + 32'(i), 1'b1, 1'b1, 1'b1);
            else       drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);
            @(negedge clk);
            chk("stream_c_valid", {31'h0, out_c_valid}, 32'h1);
            chk("stream_c_data", out_c, 32'h10 + 32'(i - 1));
        end
        drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("stream_c_end", {31'h0, out_c_valid}, 32'h0);

        // Invalid sel.
        drive(1'b1, 2'b11, 32'hFFFF0000, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("bad_in_ready", {31'h0, in_ready}, 32'h1);
        chk("bad_err_pre", {31'h0, sel_err}, 32'h0);
        drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("bad_err_pulse", {31'h0, sel_err}, 32'h1);
        chk("bad_valids", {29'h0, out_c_valid, out_b_valid, out_a_valid}, 32'h0);
        drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("bad_err_end", {31'h0, sel_err}, 32'h0);

        // Random traffic, checked by the model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        repeat (3) drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);

        // Mid-traffic reset drops in-flight words.
        drive(1'b1, 2'b01, 32'hABCD0001, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2'b01, 32'hABCD0002, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_b_valid", {31'h0, out_b_valid}, 32'h0);
        chk("midrst_b_data", out_b, 32'h0);

`ifdef DEMUX32_3_COUNT_EN
        for (int i = 0; i < 65537; i++) begin
            drive(1'b1, 2'b00, 32'(i), 1'b1, 1'b1, 1'b1);
        end
        drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("cnt_a_wrap", {16'h0, cnt_a}, 32'h1);
        chk("cnt_b_zero", {16'h0, cnt_b}, 32'h0);
        chk("cnt_c_zero", {16'h0, cnt_c}, 32'h0);
        chk("cnt_a_model", {16'h0, cnt_a}, {16'h0, m_cnt[0]});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/demux32_3_reg.md
DEMUX32_3_REG -- requirements
Module: demux32_3_reg

Interface
REQ-001 The block SHALL have these ports (clock and reset first): clk  input  1  single clock for all logic, rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 in_data  input  32  word to route.
REQ-004 in_valid  input  1  in_data and sel are valid this cycle.
REQ-005 in_ready  output  1  block accepts the word this cycle.
REQ-006 sel  input  2  destination: 00 selects A, 01 selects B, 10 selects C, 11 is invalid.
REQ-007 out_a / out_b / out_c  output  32 each  held data per destination.
REQ-008 out_a_valid / out_b_valid / out_c_valid  output  1 each  the matching out_x holds an undelivered word.
REQ-009 out_a_ready / out_b_ready / out_c_ready  input  1 each  the consumer takes out_x this cycle.
REQ-010 sel_err  output  1  one-cycle pulse when a word with sel=11 is accepted.
REQ-011 cnt_a / cnt_b / cnt_c  output  16 each  delivered-word counters; these ports exist only under DEMUX32_3_COUNT_EN.

Function
REQ-012 Each destination x SHALL be a one-entry slot with two states: EMPTY (out_x_valid=0) and FULL (out_x_valid=1).
REQ-013 An input transfer SHALL occur when in_valid && in_ready are both high on a rising clk edge.
REQ-014 in_ready SHALL be combinational and equal to:
- for sel=00/01/10: (selected slot EMPTY) || (selected slot FULL && out_x_ready).
- for sel=11: 1.
REQ-015 A transfer with sel=00/01/10 SHALL load in_data into the selected slot and set it FULL on the same edge. Out_x_valid therefore rises one cycle after acceptance.
REQ-016 A slot's output delivery SHALL occur when out_x_valid && out_x_ready.
- Delivery alone returns the slot to EMPTY.
- out_x SHALL retain its last value while the slot is EMPTY.
REQ-017 If delivery and a new load hit the same slot in one cycle, the slot SHALL remain FULL holding the new word, with no bubble.
REQ-018 A transfer with sel=11 SHALL discard the word, leave every slot unchanged, and assert sel_err for exactly the next cycle.
REQ-019 Slots SHALL operate independently. Delivery on any slot SHALL proceed regardless of the current sel value.
REQ-020 out_x and out_x_valid SHALL hold steady while out_x_valid=1 and out_x_ready=0.
REQ-021 in_ready SHALL NOT depend on in_valid.

Reset
REQ-022 While rst=1 at a clk edge, the block SHALL set:
- all slots EMPTY;
- out_a, out_b, out_c = 32'h0;
- sel_err = 0;
- counters = 16'h0.
REQ-023 Reset SHALL override a simultaneous transfer or delivery. Any word in flight is dropped.
REQ-024 in_ready SHALL be 0 while rst=1.

Configuration
REQ-025 With macro DEMUX32_3_COUNT_EN defined:
- cnt_x SHALL increment by 1 on each delivery from slot x;
- cnt_x SHALL wrap from 16'hFFFF to 16'h0000.
REQ-026 Without DEMUX32_3_COUNT_EN, the counter logic and the cnt_x ports SHALL be absent. All other behaviour SHALL be identical.

Structure
REQ-027 A shared package demux_pkg SHALL hold:
- DATA_W = 32;
- CNT_W = 16;
- the sel encodings SEL_A = 2'b00, SEL_B = 2'b01, SEL_C = 2'b10, SEL_BAD = 2'b11.
REQ-028 A sub-module demux_slot (one-entry holding register with load, deliver and optional counter) SHALL be instantiated three times. Top-level logic SHALL be limited to sel decode, in_ready and sel_err.

Verification
REQ-029 Reset: hold rst=1 for 2 cycles with in_valid=1 -> all out_x_valid=0, out_x=0, in_ready=0, sel_err=0.
REQ-030 Routing: send 32'hDEADBEEF with sel=01 while all ready=1 -> next cycle out_b_valid=1 and out_b=DEADBEEF; out_a_valid=out_c_valid=0.
REQ-031 Backpressure: hold out_a_ready=0, send sel=00 words 32'h1 then 32'h2:
- in_ready drops after the first word;
- out_a holds 1;
- raising out_a_ready delivers 1, then loads 2 with no idle cycle.
REQ-032 Simultaneous load/deliver: stream 32'h10, 32'h11, 32'h12 to C with out_c_ready=1 every cycle -> one word per cycle on out_c and out_c_valid stays high throughout.
REQ-033 Invalid sel: send 32'hFFFF_0000 with sel=11 -> in_ready=1, sel_err pulses for one cycle, no out_x_valid changes.
REQ-034 Counter wrap (DEMUX32_3_COUNT_EN): deliver 65537 words to A -> cnt_a=1, cnt_b=cnt_c=0. A build without the macro compiles with no cnt_x ports.
